// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes UART RX byte frames into register-file and ALU strobes,
// then pushes the response bytes into the TX FIFO. Single clock domain (REF_CLK).
//   AA addr data      -> register write
//   BB addr           -> register read, one response byte
//   CC opA opB fun    -> write opA to addr 0, opB to addr 1, start ALU, two response bytes
//   DD fun            -> start ALU on the stored operands, two response bytes
module sys_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ALU_WIDTH  = 16,
    parameter int unsigned FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_GATE_EN,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_Valid,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    // ALU operands live at fixed register-file locations
    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StAluA,
        StAluB,
        StAluFun,
        StAluWait,
        StTxLo,
        StTxHi
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;  // address byte of a pending write frame
    logic [DATA_WIDTH-1:0] tx_hi_q;    // upper ALU result byte, sent after the low byte
    logic                  is_alu_q;   // current frame expects a two-byte response

    // A push completes in the first cycle the request is up and the FIFO has room
    logic tx_done;
    assign tx_done = TX_D_VLD && !FIFO_FULL;

    // Frame sequencer with registered strobes, register-file/ALU controls and TX request
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            tx_hi_q     <= '0;
            is_alu_q    <= 1'b0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses
            WrEn   <= 1'b0;
            RdEn   <= 1'b0;
            ALU_EN <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (RX_D_VLD) begin
                        is_alu_q <= (RX_P_DATA == CMD_ALU_OP) || (RX_P_DATA == CMD_ALU_NOP);
                        if (RX_P_DATA == CMD_WR) begin
                            state_q <= StWrAddr;
                        end else if (RX_P_DATA == CMD_RD) begin
                            state_q <= StRdAddr;
                        end else if (RX_P_DATA == CMD_ALU_OP) begin
                            state_q <= StAluA;
                        end else if (RX_P_DATA == CMD_ALU_NOP) begin
                            state_q <= StAluFun;
                        end
                        // unknown command bytes are dropped
                    end
                end

                StWrAddr: begin
                    if (RX_D_VLD) begin
                        wr_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q   <= StWrData;
                    end
                end

                StWrData: begin
                    if (RX_D_VLD) begin
                        WrEn    <= 1'b1;
                        Address <= wr_addr_q;
                        WrData  <= RX_P_DATA;
                        state_q <= StIdle;
                    end
                end

                StRdAddr: begin
                    if (RX_D_VLD) begin
                        RdEn    <= 1'b1;
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q <= StRdWait;
                    end
                end

                StRdWait: begin
                    if (RdData_Valid) begin
                        TX_P_DATA <= RdData;
                        TX_D_VLD  <= 1'b1;
                        state_q   <= StTxLo;
                    end
                end

                StAluA: begin
                    if (RX_D_VLD) begin
                        WrEn    <= 1'b1;
                        Address <= OPA_ADDR;
                        WrData  <= RX_P_DATA;
                        state_q <= StAluB;
                    end
                end

                StAluB: begin
                    if (RX_D_VLD) begin
                        WrEn    <= 1'b1;
                        Address <= OPB_ADDR;
                        WrData  <= RX_P_DATA;
                        state_q <= StAluFun;
                    end
                end

                StAluFun: begin
                    if (RX_D_VLD) begin
                        ALU_EN      <= 1'b1;
                        ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                        CLK_GATE_EN <= 1'b1;
                        state_q     <= StAluWait;
                    end
                end

                StAluWait: begin
                    // gate stays open through the result cycle and the one after it
                    if (OUT_Valid) begin
                        TX_P_DATA <= ALU_OUT[DATA_WIDTH-1:0];
                        tx_hi_q   <= ALU_OUT[ALU_WIDTH-1:DATA_WIDTH];
                        TX_D_VLD  <= 1'b1;
                        state_q   <= StTxLo;
                    end
                end

                StTxLo: begin
                    CLK_GATE_EN <= 1'b0;
                    if (tx_done) begin
                        if (is_alu_q) begin
                            TX_P_DATA <= tx_hi_q;
                            state_q   <= StTxHi;
                        end else begin
                            TX_D_VLD <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end

                StTxHi: begin
                    if (tx_done) begin
                        TX_D_VLD <= 1'b0;
                        state_q  <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: transaction-level expectations (queues of register writes, reads,
// ALU starts and TX bytes with their due cycles), one per-cycle compare process, directed
// scenarios with literal expectations, then a randomized frame mix.
module tb_sys_cmd_ctrl;

    logic        REF_CLK_TB = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        WrEn, RdEn;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [15:0] ALU_OUT;
    logic        OUT_Valid;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;

    sys_cmd_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .ALU_WIDTH (16),
        .FUN_WIDTH (4)
    ) dut (
        .CLK         (REF_CLK_TB),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .RdData      (RdData),
        .RdData_Valid(RdData_Valid),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .CLK_GATE_EN (CLK_GATE_EN),
        .ALU_OUT     (ALU_OUT),
        .OUT_Valid   (OUT_Valid),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .FIFO_FULL   (FIFO_FULL)
    );

    always #5 REF_CLK_TB = ~REF_CLK_TB;

    int cyc = 0;
    always @(posedge REF_CLK_TB) cyc <= cyc + 1;

    typedef struct { int due; logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int due; logic [3:0] addr; } rd_t;
    typedef struct { int due; logic [3:0] fun; } alu_t;

    wr_t        wr_q[$];
    rd_t        rd_q[$];
    alu_t       alu_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx_log[$];

    int total = 0;
    int bad   = 0;
    int n_wr = 0, n_rd = 0, n_alu = 0, n_tx = 0, n_stall = 0;
    logic [3:0] last_wr_addr, last_rd_addr, last_fun;
    logic [7:0] last_wr_data;
    int full_mode = 0;  // 0: never full, 1: random, 2: held full

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input int due, input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.due = due; e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    // FIFO full generator
    initial begin
        FIFO_FULL = 1'b0;
        forever begin
            @(posedge REF_CLK_TB);
            #2;
            if (full_mode == 0)      FIFO_FULL = 1'b0;
            else if (full_mode == 1) FIFO_FULL = ($urandom_range(0, 2) == 0);
            else                     FIFO_FULL = 1'b1;
        end
    end

    // Per-cycle compare against the expectation queues and the gate/handshake rules
    initial begin
        bit         gate_on = 1'b0;
        bit         ov_prev = 1'b0;
        bit         stall_prev = 1'b0;
        logic [7:0] stall_data = 8'h00;
        int         tx_due = -1;
        forever begin
            @(negedge REF_CLK_TB);
            if (RST) begin
                gate_on = 1'b0; ov_prev = 1'b0; stall_prev = 1'b0; tx_due = -1;
            end else begin
                if (WrEn) begin
                    if (wr_q.size() == 0) check("unexpected_wren", 1, 0);
                    else begin
                        wr_t e;
                        e = wr_q.pop_front();
                        check("wr_cycle", 32'(cyc), 32'(e.due));
                        check("wr_addr", 32'(Address), 32'(e.addr));
                        check("wr_data", 32'(WrData), 32'(e.data));
                    end
                    n_wr++; last_wr_addr = Address; last_wr_data = WrData;
                end
                if (RdEn) begin
                    if (rd_q.size() == 0) check("unexpected_rden", 1, 0);
                    else begin
                        rd_t e;
                        e = rd_q.pop_front();
                        check("rd_cycle", 32'(cyc), 32'(e.due));
                        check("rd_addr", 32'(Address), 32'(e.addr));
                    end
                    n_rd++; last_rd_addr = Address;
                end
                if (ALU_EN) begin
                    if (alu_q.size() == 0) check("unexpected_alu_en", 1, 0);
                    else begin
                        alu_t e;
                        e = alu_q.pop_front();
                        check("alu_cycle", 32'(cyc), 32'(e.due));
                        check("alu_fun", 32'(ALU_FUN), 32'(e.fun));
                    end
                    n_alu++; last_fun = ALU_FUN;
                    gate_on = 1'b1;
                end
                if (tx_due == cyc) check("tx_onset", 32'(TX_D_VLD), 1);
                if (RdData_Valid || OUT_Valid) tx_due = cyc + 1;
                if (stall_prev) begin
                    check("tx_hold_vld", 32'(TX_D_VLD), 1);
                    check("tx_hold_data", 32'(TX_P_DATA), 32'(stall_data));
                end
                stall_prev = TX_D_VLD && FIFO_FULL;
                stall_data = TX_P_DATA;
                if (stall_prev) n_stall++;
                if (TX_D_VLD && !FIFO_FULL) begin
                    if (tx_q.size() == 0) check("unexpected_push", 1, 0);
                    else check("tx_byte", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
                    n_tx++;
                    tx_log.push_back(TX_P_DATA);
                end
                check("clk_gate_en", 32'(CLK_GATE_EN), 32'(gate_on));
                if (ov_prev) gate_on = 1'b0;
                ov_prev = OUT_Valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge REF_CLK_TB);
            #1;
        end
    endtask

    // Sends one byte; c is the cycle RX_D_VLD is high. Returns in cycle c+1.
    task automatic send_byte(input logic [7:0] b, output int c);
        tick($urandom_range(0, 2));
        tick(1);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        c = cyc;
        tick(1);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while ((tx_q.size() != 0 || TX_D_VLD) && k < 300) begin
            tick(1);
            k++;
        end
        if (k >= 300) check("drain_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] d);
        int c;
        send_byte(8'hAA, c);
        send_byte(ab, c);
        send_byte(d, c);
        exp_wr(c + 1, ab[3:0], d);
    endtask

    task automatic do_read(input logic [7:0] ab, input logic [7:0] d, input int dly);
        int c;
        int k = 0;
        rd_t e;
        send_byte(8'hBB, c);
        send_byte(ab, c);
        e.due = c + 1; e.addr = ab[3:0];
        rd_q.push_back(e);
        while (!RdEn && k < 20) begin tick(1); k++; end
        if (k >= 20) check("rden_timeout", 0, 1);
        for (int i = 1; i <= dly; i++) begin
            tick(1);
            RX_D_VLD = (i == 1);  // stray byte while waiting is dropped
            RX_P_DATA = 8'($urandom);
            if (i == dly) begin
                RdData_Valid = 1'b1;
                RdData = d;
            end
        end
        tx_q.push_back(d);
        tick(1);
        RdData_Valid = 1'b0;
        RX_D_VLD = 1'b0;
        RdData = 8'($urandom);
        drain();
    endtask

    task automatic do_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input logic [15:0] res, input int dly,
                          input bit stall);
        int c;
        int k = 0;
        int s0;
        alu_t e;
        if (ops) begin
            send_byte(8'hCC, c);
            send_byte(a, c);
            exp_wr(c + 1, 4'd0, a);
            send_byte(b, c);
            exp_wr(c + 1, 4'd1, b);
        end else begin
            send_byte(8'hDD, c);
        end
        send_byte(f, c);
        e.due = c + 1; e.fun = f[3:0];
        alu_q.push_back(e);
        while (!ALU_EN && k < 20) begin tick(1); k++; end
        if (k >= 20) check("alu_en_timeout", 0, 1);
        if (stall) full_mode = 2;
        for (int i = 1; i <= dly; i++) begin
            tick(1);
            RX_D_VLD = (i == 1);
            RX_P_DATA = 8'($urandom);
            if (i == dly) begin
                OUT_Valid = 1'b1;
                ALU_OUT = res;
            end
        end
        tx_q.push_back(res[7:0]);
        tx_q.push_back(res[15:8]);
        tick(1);
        OUT_Valid = 1'b0;
        RX_D_VLD = 1'b0;
        s0 = n_stall;
        if (stall) begin
            tick(5);
            full_mode = 0;
        end
        drain();
        if (stall) check("stall_cycles", 32'(n_stall - s0), 5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, t0, c;
        logic [7:0] jb;
        RST = 1'b1;
        RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
        RdData = 8'h00; RdData_Valid = 1'b0;
        ALU_OUT = 16'h0000; OUT_Valid = 1'b0;
        tick(3);
        check("rst_wren", 32'(WrEn), 0);
        check("rst_rden", 32'(RdEn), 0);
        check("rst_alu_en", 32'(ALU_EN), 0);
        check("rst_gate", 32'(CLK_GATE_EN), 0);
        check("rst_tx_vld", 32'(TX_D_VLD), 0);
        check("rst_outs", {4'(Address), WrData, 4'(ALU_FUN), TX_P_DATA}, 0);
        RST = 1'b0;
        tick(2);

        // 1: plain write
        w0 = n_wr; t0 = n_tx;
        do_write(8'h05, 8'h0A);
        tick(2);
        check("t1_wr_count", 32'(n_wr - w0), 1);
        check("t1_addr", 32'(last_wr_addr), 32'h5);
        check("t1_data", 32'(last_wr_data), 32'h0A);
        check("t1_no_tx", 32'(n_tx - t0), 0);

        // 2: read with data 3 cycles after RdEn
        t0 = n_tx;
        do_read(8'h05, 8'h0A, 3);
        check("t2_rd_addr", 32'(last_rd_addr), 32'h5);
        check("t2_tx_count", 32'(n_tx - t0), 1);
        check("t2_tx_byte", 32'(tx_log[$]), 32'h0A);

        // 3: ALU with operands
        w0 = n_wr; t0 = n_tx;
        do_alu(1'b1, 8'h01, 8'h02, 8'h00, 16'h0003, 2, 1'b0);
        check("t3_wr_count", 32'(n_wr - w0), 2);
        check("t3_fun", 32'(last_fun), 32'h0);
        check("t3_tx_count", 32'(n_tx - t0), 2);
        check("t3_tx_lo", 32'(tx_log[$-1]), 32'h03);
        check("t3_tx_hi", 32'(tx_log[$]), 32'h00);

        // 4: ALU without operands
        w0 = n_wr; t0 = n_tx;
        do_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h0002, 4, 1'b0);
        check("t4_wr_count", 32'(n_wr - w0), 0);
        check("t4_fun", 32'(last_fun), 32'h2);
        check("t4_tx_lo", 32'(tx_log[$-1]), 32'h02);
        check("t4_tx_hi", 32'(tx_log[$]), 32'h00);

        // 5: FIFO full for 5 cycles while the low byte waits
        t0 = n_tx;
        do_alu(1'b0, 8'h00, 8'h00, 8'h07, 16'hBEEF, 2, 1'b1);
        check("t5_tx_count", 32'(n_tx - t0), 2);
        check("t5_tx_lo", 32'(tx_log[$-1]), 32'hEF);
        check("t5_tx_hi", 32'(tx_log[$]), 32'hBE);

        // 6: junk byte, partial ALU frame, reset mid-frame, then a clean write
        send_byte(8'h55, c);
        send_byte(8'hCC, c);
        send_byte(8'h01, c);
        exp_wr(c + 1, 4'd0, 8'h01);
        tick(1);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        w0 = n_wr; t0 = n_tx;
        tick(5);
        check("t6_no_strobe", 32'(n_wr - w0), 0);
        check("t6_no_push", 32'(n_tx - t0), 0);
        check("t6_rst_wrdata", 32'(WrData), 0);
        do_write(8'h06, 8'hA5);
        tick(2);
        check("t6_addr", 32'(last_wr_addr), 32'h6);
        check("t6_data", 32'(last_wr_data), 32'hA5);

        // randomized frame mix with random FIFO back-pressure
        full_mode = 1;
        repeat (60) begin
            case ($urandom_range(0, 4))
                0: begin
                    jb = 8'($urandom);
                    if (jb == 8'hAA || jb == 8'hBB || jb == 8'hCC || jb == 8'hDD) jb = jb ^ 8'h01;
                    send_byte(jb, c);
                end
                1: do_write(8'($urandom), 8'($urandom));
                2: do_read(8'($urandom), 8'($urandom), $urandom_range(1, 5));
                3: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                          $urandom_range(1, 6), 1'b0);
                default: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                                $urandom_range(1, 6), 1'b0);
            endcase
        end
        full_mode = 0;
        tick(10);
        check("left_wr", 32'(wr_q.size()), 0);
        check("left_rd", 32'(rd_q.size()), 0);
        check("left_alu", 32'(alu_q.size()), 0);
        check("left_tx", 32'(tx_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
